timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped 32-bit down-counting timer attached to the `mips` core's system bridge as a peripheral, sitting directly downstream of the CPU's store/load path and upstream of its interrupt input. The CPU programs a preset value and control word through a word-addressed register interface; the block counts down once per clock and raises a maskable interrupt request on expiry. It supports one-shot and auto-reload modes.

## Interface
Parameters: none.

- `clk`  in  1  system clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `addr`  in  2  word select, bridge address bits [3:2]: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved
- `we`  in  1  write strobe, sampled on rising `clk`
- `din`  in  32  write data
- `dout`  out  32  combinational read data for `addr`; reserved word reads 0
- `irq`  out  1  interrupt request to CPU, level, = `irq_flag & CTRL.IM`

## Operation
- CTRL: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 10/11 behave as 00 but read back as written), bit3 IM (interrupt mask, 1 = enabled); bits[31:4] read 0, ignored on write.
- PRESET: 32-bit read/write. COUNT: read-only; writes ignored. Reserved word: writes ignored.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 -> LOAD; else stay.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT: EN=0 -> IDLE, COUNT frozen. Else COUNT > 1: COUNT <= COUNT-1. Else (COUNT ≤ 1): COUNT <= 0, `irq_flag` <= 1, -> INT.
  - INT: MODE one-shot: EN <= 0, -> IDLE. MODE auto-reload: -> LOAD.
- `irq_flag` sticky; cleared by any write to CTRL. When set and clear coincide on one edge, set wins.
- CPU write to CTRL takes priority over the FSM's one-shot EN clear on the same edge.
- PRESET write during CNT does not alter COUNT; used at next LOAD.
- Counter arithmetic is unsigned 32-bit; no wrap below 0 (COUNT saturates at 0).
- Reset: CTRL = 0, PRESET = 0, COUNT = 0, `irq_flag` = 0, state IDLE; hence `irq` = 0 and `dout` reflects zeros. Reset mid-count aborts without interrupt.

## Timing
- Register writes take effect at the rising edge sampling `we`; reads are same-cycle combinational.
- Write CTRL.EN=1 at edge E0 (state IDLE): E1 -> LOAD, E2 COUNT = PRESET (P) and -> CNT.
- P ≥ 2: COUNT reaches 1 at E(P+1); at E(P+2) COUNT = 0, `irq_flag` = 1, state INT. P = 0 or 1: flag set at E3.
- `irq` asserted the cycle after the flag-setting edge if IM=1; IM change takes effect combinationally.
- Auto-reload period: P+2 cycles from one flag-setting edge to the next CNT->INT edge (INT, LOAD overhead), P ≥ 1.
- Clearing EN during CNT: next edge -> IDLE; restart reloads PRESET.

## Structure
- Shared package `tc_pkg`: state encoding (2-bit IDLE/LOAD/CNT/INT), word offsets CTRL/PRESET/COUNT, MODE constants, CTRL bit positions.
- Single module; no sub-module. Register file, FSM and read mux live together.

## Test plan
- Reset mid-count (P=100, assert `reset` at cycle 50) -> COUNT=0, state IDLE, `irq`=0 immediately, no later interrupt.
- One-shot: PRESET=5, CTRL=0x9 -> COUNT reads 5,4,3,2,1,0; `irq`=1 after E7; CTRL reads 0x8; write CTRL=0x8 -> `irq`=0.
- Auto-reload: PRESET=3, CTRL=0xB -> flag-setting edges every 5 cycles; COUNT cycles 3,2,1,0,0(LOAD),3...; `irq` stays 1 until CTRL written.
- Mask: PRESET=2, CTRL=0x1 -> `irq`=0 at expiry, flag set; write-free read path then set IM via CTRL=0x8 clears flag -> `irq` stays 0 (proves clear-on-write).
- Pause/edge cases: PRESET=0 -> flag at E3; CTRL EN=0 at COUNT=7 -> COUNT holds 7; PRESET write 9 during CNT -> current count unaffected, next reload 9.
- Collision: CTRL write on same edge as CNT->INT -> `irq_flag`=1 and CTRL takes written value.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared definitions for the memory-mapped timer: state encoding,
// register word offsets, mode values and CTRL bit positions.
package tc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM_BIT  = 3;

endpackage

// File: rtl/timer_counter_if.sv
// Word-addressed register bus between the CPU bridge (master) and the timer (slave).
interface timer_counter_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, output we, output din, input dout, input irq);
  modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/timer_counter.sv
// 32-bit down-counting timer with one-shot / auto-reload modes and a
// sticky, maskable expiry flag. Register file, FSM and read mux in one module.
//
// state | meaning
// IDLE  | waiting for CTRL.EN
// LOAD  | copy PRESET into COUNT
// CNT   | decrementing; pauses back to IDLE if EN drops
// INT   | expiry seen; reload or clear EN depending on MODE
module timer_counter
  import tc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  state_t      state, state_nxt;
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count, count_nxt;
  logic        irq_flag;
  logic        flag_set;
  logic        ctrl_en_clr;
  logic        ctrl_wr;
  logic        preset_wr;

  assign ctrl_wr   = bus.we && (bus.addr == ADDR_CTRL);
  assign preset_wr = bus.we && (bus.addr == ADDR_PRESET);

  // Next-state, next-count and side-effect strobes for the sequencing FSM.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    flag_set    = 1'b0;
    ctrl_en_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          state_nxt = ST_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          // Values of 0 and 1 both expire here, so COUNT never wraps.
          count_nxt = 32'd0;
          flag_set  = 1'b1;
          state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl_mode == MODE_RELOAD) begin
          state_nxt = ST_LOAD;
        end else begin
          ctrl_en_clr = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= 32'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // CTRL register; a CPU write overrides the one-shot EN clear on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= MODE_ONESHOT;
      ctrl_im   <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl_en   <= bus.din[CTRL_EN_BIT];
      ctrl_mode <= bus.din[CTRL_MODE_HI:CTRL_MODE_LO];
      ctrl_im   <= bus.din[CTRL_IM_BIT];
    end else if (ctrl_en_clr) begin
      ctrl_en   <= 1'b0;
    end
  end

  // PRESET register; only consumed in LOAD, so mid-count writes apply next reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      preset <= 32'd0;
    end else if (preset_wr) begin
      preset <= bus.din;
    end
  end

  // Sticky expiry flag; setting beats a same-edge clear from a CTRL write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_flag <= 1'b0;
    end else if (flag_set) begin
      irq_flag <= 1'b1;
    end else if (ctrl_wr) begin
      irq_flag <= 1'b0;
    end
  end

  // Combinational read mux; the reserved word reads as zero.
  always_comb begin
    bus.dout = 32'd0;
    case (bus.addr)
      ADDR_CTRL:   bus.dout = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
      ADDR_PRESET: bus.dout = preset;
      ADDR_COUNT:  bus.dout = count;
      default:     bus.dout = 32'd0;
    endcase
  end

  assign bus.irq = irq_flag & ctrl_im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a vector table for the main one-shot and
// auto-reload sequences plus hand-written multi-cycle corner cases.
module tb_timer_counter;
  import tc_pkg::*;

  logic clk;
  logic reset;
  timer_counter_if bus();

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic we, input logic [1:0] wa, input logic [31:0] wd,
                              input logic [1:0] ra, input logic [31:0] ed, input logic ei);
    vec_t v;
    v.we = we; v.waddr = wa; v.wdata = wd;
    v.raddr = ra; v.exp_dout = ed; v.exp_irq = ei;
    vt.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock with the given bus write; returns #1 after the rising edge.
  task automatic step(input logic we, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we   = we;
    bus.addr = a;
    bus.din  = d;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, ADDR_RSVD, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.dout;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    bus.we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] rv;
  logic        irq_seen;
  logic        cnt_nonzero;

  initial begin
    reset    = 1'b1;
    bus.we   = 1'b0;
    bus.addr = ADDR_CTRL;
    bus.din  = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    rd(ADDR_CTRL, rv);   chk("reset_ctrl", rv, 32'd0);
    rd(ADDR_PRESET, rv); chk("reset_preset", rv, 32'd0);
    rd(ADDR_COUNT, rv);  chk("reset_count", rv, 32'd0);
    chk("reset_irq", {31'd0, bus.irq}, 32'd0);

    // One-shot, PRESET=5, IM=1
    add(1, ADDR_PRESET, 32'd5, ADDR_PRESET, 32'd5, 0);
    add(1, ADDR_CTRL,   32'h9, ADDR_COUNT,  32'd0, 0);  // E0
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd0, 0);  // E1 LOAD
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd5, 0);  // E2
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd4, 0);
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd3, 0);
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd2, 0);
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd1, 0);  // E6
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd0, 1);  // E7 expiry
    add(0, ADDR_RSVD,   0,     ADDR_CTRL,   32'h8, 1);  // E8 EN cleared
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd0, 1);
    add(1, ADDR_CTRL,   32'h8, ADDR_CTRL,   32'h8, 0);  // clear flag
    add(1, ADDR_COUNT,  32'h1234, ADDR_COUNT, 32'd0, 0);
    add(1, ADDR_RSVD,   32'hFFFF_FFFF, ADDR_RSVD, 32'd0, 0);
    add(1, ADDR_CTRL,   32'hFFFF_FFF4, ADDR_CTRL, 32'h4, 0);
    // Auto-reload, PRESET=3, IM=1
    add(1, ADDR_PRESET, 32'd3, ADDR_PRESET, 32'd3, 0);
    add(1, ADDR_CTRL,   32'hB, ADDR_COUNT,  32'd0, 0);  // E0
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd0, 0);  // E1 LOAD
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd3, 0);
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd2, 0);
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd1, 0);
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd0, 1);  // E5 expiry
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd0, 1);  // E6 LOAD
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd3, 1);
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd2, 1);
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd1, 1);
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd0, 1);  // E10 expiry
    add(1, ADDR_CTRL,   32'h8, ADDR_CTRL,   32'h8, 0);  // E11 INT->LOAD, EN off
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd3, 0);  // E12 load
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd3, 0);  // E13 -> IDLE
    add(0, ADDR_RSVD,   0,     ADDR_COUNT,  32'd3, 0);

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].we, vt[i].waddr, vt[i].wdata);
      rd(vt[i].raddr, rv);
      chk($sformatf("vec%0d_dout", i), rv, vt[i].exp_dout);
      chk($sformatf("vec%0d_irq", i), {31'd0, bus.irq}, {31'd0, vt[i].exp_irq});
    end

    // Masked expiry: flag sets but irq stays low; CTRL write with IM=1 clears it.
    do_reset();
    step(1, ADDR_PRESET, 32'd2);
    step(1, ADDR_CTRL, 32'h1);
    repeat (3) idle();
    idle();
    rd(ADDR_COUNT, rv); chk("mask_count", rv, 32'd0);
    chk("mask_irq_expiry", {31'd0, bus.irq}, 32'd0);
    idle();
    rd(ADDR_CTRL, rv); chk("mask_ctrl_en_cleared", rv, 32'h0);
    step(1, ADDR_CTRL, 32'h8);
    chk("mask_irq_after_im", {31'd0, bus.irq}, 32'd0);

    // PRESET=0 expires at E3.
    do_reset();
    step(1, ADDR_PRESET, 32'd0);
    step(1, ADDR_CTRL, 32'h9);
    idle(); idle();
    chk("p0_irq_e2", {31'd0, bus.irq}, 32'd0);
    idle();
    chk("p0_irq_e3", {31'd0, bus.irq}, 32'd1);

    // Pause at 7, hold, then restart reloads PRESET.
    do_reset();
    step(1, ADDR_PRESET, 32'd10);
    step(1, ADDR_CTRL, 32'h1);
    repeat (4) idle();
    rd(ADDR_COUNT, rv); chk("pause_count8", rv, 32'd8);
    step(1, ADDR_CTRL, 32'h0);
    rd(ADDR_COUNT, rv); chk("pause_count7", rv, 32'd7);
    idle(); idle();
    rd(ADDR_COUNT, rv); chk("pause_hold7", rv, 32'd7);
    step(1, ADDR_CTRL, 32'h1);
    idle(); idle();
    rd(ADDR_COUNT, rv); chk("pause_restart_reload", rv, 32'd10);

    // PRESET write mid-count applies only at the next reload.
    do_reset();
    step(1, ADDR_PRESET, 32'd4);
    step(1, ADDR_CTRL, 32'h3);
    idle(); idle();
    step(1, ADDR_PRESET, 32'd9);
    rd(ADDR_COUNT, rv); chk("midpreset_count", rv, 32'd3);
    repeat (4) idle();
    idle();
    rd(ADDR_COUNT, rv); chk("midpreset_reload", rv, 32'd9);

    // Collision: CTRL write on the CNT->INT edge, then on the one-shot EN-clear edge.
    do_reset();
    step(1, ADDR_PRESET, 32'd2);
    step(1, ADDR_CTRL, 32'h3);
    repeat (3) idle();
    step(1, ADDR_CTRL, 32'h9);
    rd(ADDR_CTRL, rv); chk("coll_ctrl", rv, 32'h9);
    chk("coll_irq", {31'd0, bus.irq}, 32'd1);
    step(1, ADDR_CTRL, 32'hB);
    rd(ADDR_CTRL, rv); chk("coll_ctrl_wins", rv, 32'hB);
    chk("coll_irq_cleared", {31'd0, bus.irq}, 32'd0);

    // Reset mid-count aborts without interrupt.
    do_reset();
    step(1, ADDR_PRESET, 32'd100);
    step(1, ADDR_CTRL, 32'h9);
    repeat (50) idle();
    #2 reset = 1'b1;
    #1;
    rd(ADDR_COUNT, rv);  chk("rst_mid_count", rv, 32'd0);
    rd(ADDR_CTRL, rv);   chk("rst_mid_ctrl", rv, 32'd0);
    rd(ADDR_PRESET, rv); chk("rst_mid_preset", rv, 32'd0);
    chk("rst_mid_irq", {31'd0, bus.irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    irq_seen    = 1'b0;
    cnt_nonzero = 1'b0;
    for (int i = 0; i < 120; i++) begin
      idle();
      rd(ADDR_COUNT, rv);
      if (rv != 32'd0) cnt_nonzero = 1'b1;
      if (bus.irq) irq_seen = 1'b1;
    end
    chk("rst_mid_no_irq", {31'd0, irq_seen}, 32'd0);
    chk("rst_mid_count_idle", {31'd0, cnt_nonzero}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
